// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result/flags and valid/ready handshakes.
// Define ALU_MUL_EN to build in the iterative shift-add multiplier for code 1001.
module alu_exec_unit #(
  parameter  int WIDTH = 32,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SW-1:0]    Shamt,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             Err
);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_XOR = 4'b0011, OP_NOR = 4'b0100, OP_SLL = 4'b0101,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SRL = 4'b1000,
                         OP_MUL = 4'b1001, OP_GEZ = 4'b1010, OP_GTZ = 4'b1011,
                         OP_LEZ = 4'b1100, OP_LTZ = 4'b1101;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
  logic             accept;

  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf, alu_err, a_neg, a_zero;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_nx;
  logic [SW-1:0]    cnt_q, cnt_d;

  assign InReady = (state_q == S_IDLE) && (!out_valid_q || OutReady);
`else
  assign InReady = !out_valid_q || OutReady;
`endif

  assign accept = InValid && InReady;
  assign sum    = A + B;
  assign diff   = A - B;
  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);

  // Single-cycle datapath; MUL lands in the reserved arm when the engine is absent.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (ALUControl)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOR: alu_res = ~(A | B);
      OP_SLL: alu_res = B << Shamt;
      OP_SRL: alu_res = B >> Shamt;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: alu_res[0] = $signed(A) < $signed(B);
      OP_GEZ: alu_res[0] = !a_neg;
      OP_GTZ: alu_res[0] = !a_neg && !a_zero;
      OP_LEZ: alu_res[0] = a_neg || a_zero;
      OP_LTZ: alu_res[0] = a_neg;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q && !OutReady;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nx   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    if (state_q == S_MUL) begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == SW'(WIDTH-1)) begin
        result_d    = acc_nx;
        zero_d      = (acc_nx == '0);
        ovf_d       = 1'b0;
        err_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
    end else
`endif
    if (accept) begin
`ifdef ALU_MUL_EN
      if (ALUControl == OP_MUL) begin
        mcand_d  = A;
        mplier_d = B;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_MUL;
      end else
`endif
      begin
        result_d    = alu_res;
        zero_d      = (alu_res == '0);
        ovf_d       = alu_ovf;
        err_d       = alu_err;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign OutValid = out_valid_q;
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; expectations follow ALU_MUL_EN if defined.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         Clk = 1'b0, Reset_n = 1'b0;
  logic         InValid = 1'b0, InReady, OutValid, OutReady = 1'b1;
  logic [3:0]   ALUControl = 4'b0;
  logic [W-1:0] A = '0, B = '0, Result;
  logic [4:0]   Shamt = '0;
  logic         Zero, Overflow, Err;
  int           total = 0, bad = 0;
  logic         seen;

  alu_exec_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .A(A), .B(B), .Shamt(Shamt),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .Zero(Zero), .Overflow(Overflow), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [4:0] sh);
    InValid = 1'b1; ALUControl = c; A = a; B = b; Shamt = sh;
  endtask

  // After an accepted single-cycle op: check result and all flags.
  task automatic res(input string tag, input logic [W-1:0] r, input logic z,
                     input logic o, input logic e);
    chk({tag, ".vld"}, W'(OutValid), 1);
    chk({tag, ".res"}, Result, r);
    chk({tag, ".flg"}, {29'b0, Zero, Overflow, Err}, {29'b0, z, o, e});
  endtask

  initial begin
    tick(); tick();
    chk("rst.vld", W'(OutValid), 0);
    chk("rst.res", Result, 0);
    chk("rst.flg", {29'b0, Zero, Overflow, Err}, 0);
    Reset_n = 1'b1;
    #1;
    chk("rst.rdy", W'(InReady), 1);

    op(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);      tick(); res("add_ovf", 32'h8000_0000, 0, 1, 0);
    op(4'b0110, 32'd5, 32'd5, 5'd0);               tick(); res("sub_zero", 32'h0, 1, 0, 0);
    op(4'b0110, 32'h8000_0000, 32'h1, 5'd0);       tick(); res("sub_ovf", 32'h7FFF_FFFF, 0, 1, 0);
    op(4'b0101, 32'h0, 32'h1, 5'd31);              tick(); res("sll31", 32'h8000_0000, 0, 0, 0);
    op(4'b1000, 32'h0, 32'h8000_0000, 5'd4);       tick(); res("srl4", 32'h0800_0000, 0, 0, 0);
    op(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);       tick(); res("slt", 32'h1, 0, 0, 0);
    op(4'b1101, 32'h0, 32'h0, 5'd0);               tick(); res("ltz0", 32'h0, 1, 0, 0);
    op(4'b1010, 32'h0, 32'h0, 5'd0);               tick(); res("gez0", 32'h1, 0, 0, 0);
    op(4'b1011, 32'h0, 32'h0, 5'd0);               tick(); res("gtz0", 32'h0, 1, 0, 0);
    op(4'b1100, 32'h0, 32'h0, 5'd0);               tick(); res("lez0", 32'h1, 0, 0, 0);
    op(4'b0100, 32'h0, 32'h0, 5'd0);               tick(); res("nor", 32'hFFFF_FFFF, 0, 0, 0);
    op(4'b0011, 32'hA5A5_0000, 32'hFFFF_0000, 5'd0); tick(); res("xor", 32'h5A5A_0000, 0, 0, 0);
    op(4'b1110, 32'h1234, 32'h5678, 5'd0);         tick(); res("rsv", 32'h0, 1, 0, 1);
    InValid = 1'b0; tick();
    chk("idle.vld", W'(OutValid), 0);

    op(4'b1001, 32'hFFFF_FFFF, 32'h3, 5'd0);
    tick();
`ifdef ALU_MUL_EN
    // Present another op during the multiply; it must be ignored.
    op(4'b0010, 32'h1, 32'h1, 5'd0);
    seen = 1'b0;
    for (int i = 1; i < W; i++) begin
      if (InReady || OutValid) seen = 1'b1;
      tick();
    end
    chk("mul.busy", W'(seen | InReady | OutValid), 0);
    InValid = 1'b0;
    tick();
    res("mul", 32'hFFFF_FFFD, 0, 0, 0);
`else
    InValid = 1'b0;
    res("mul_off", 32'h0, 1, 0, 1);
`endif
    tick();
    chk("idle2.vld", W'(OutValid), 0);

    OutReady = 1'b0;
    op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); tick(); res("and", 32'hF000_F000, 0, 0, 0);
    op(4'b0001, 32'h0000_000F, 32'h0000_00F0, 5'd0);
    tick(); tick();
    res("bp.hold", 32'hF000_F000, 0, 0, 0);
    chk("bp.rdy", W'(InReady), 0);
    OutReady = 1'b1;
    #1;
    chk("bp.rdy1", W'(InReady), 1);
    tick(); res("bp.or", 32'h0000_00FF, 0, 0, 0);
    InValid = 1'b0; tick();
    chk("bp.drain", W'(OutValid), 0);

`ifdef ALU_MUL_EN
    op(4'b1001, 32'd7, 32'd5, 5'd0);
    tick();
    InValid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    Reset_n = 1'b0;
    #1;
    chk("mrst.vld", W'(OutValid), 0);
    tick();
    Reset_n = 1'b1;
    #1;
    chk("mrst.rdy", W'(InReady), 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (OutValid) seen = 1'b1;
    end
    chk("mrst.novld", W'(seen), 0);
`endif
    op(4'b0010, 32'd2, 32'd3, 5'd0); tick(); res("add_post", 32'd5, 0, 0, 0);
    InValid = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU for the MIPS datapath that consumes the 4-bit `ALUControl` code produced by the ALU controller, together with the operands, and returns a registered result with flags. Simple ops complete in one cycle. `MUL` runs on an iterative shift-add engine. Valid/ready handshakes on both sides let the pipeline stall while a multiply is in progress.

## Interface
- `WIDTH`, 32, operand/result width; the shift amount width is $clog2(WIDTH).
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  operands and `ALUControl` are valid.
- `InReady`  out  1  unit can accept an op this cycle.
- `ALUControl`  in  4  operation code, encoded below.
- `A`  in  WIDTH  operand A (rs).
- `B`  in  WIDTH  operand B (rt or sign/zero-extended immediate).
- `Shamt`  in  $clog2(WIDTH)  shift amount for SLL/SRL.
- `OutValid`  out  1  `Result` and flags are valid.
- `OutReady`  in  1  downstream consumes the result.
- `Result`  out  WIDTH  operation result.
- `Zero`  out  1  high when `Result == 0`.
- `Overflow`  out  1  signed overflow, ADD/SUB only.
- `Err`  out  1  reserved or disabled code was executed.

## Operation
- ALUControl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLL (B<<Shamt), 0110 SUB (A−B), 0111 SLT (signed, result 1/0).
  - 1000 SRL (B>>Shamt, logical), 1001 MUL (low WIDTH bits of A×B).
  - 1010 GEZ (A≥0), 1011 GTZ (A>0), 1100 LEZ (A≤0), 1101 LTZ (A<0); each result is 1/0 and the branch is taken on `Result[0]`.
  - 1110, 1111 reserved: `Result`=0, `Zero`=1, `Err`=1.
- ADD/SUB wrap modulo 2^WIDTH. `Overflow` is set when the operand signs match (ADD) or differ (SUB) and the result sign differs from A. `Overflow` is 0 for every other op.
- `InReady` = (state==IDLE) && (!OutValid || OutReady), driven combinationally. An op is accepted on an edge where `InValid && InReady`.
- State machine:
  - IDLE: accept a non-MUL op → write `Result`/flags, set `OutValid`, stay in IDLE. Accept MUL → load multiplicand=A, multiplier=B, acc=0, count=0, go to MUL.
  - MUL: on each edge, if multiplier[0] add the multiplicand to acc; then multiplicand<<=1, multiplier>>=1, count++. On the edge where count==WIDTH−1, write acc (including that iteration) to `Result`, set `OutValid`, go to IDLE.
- `OutValid` clears on an edge with `OutReady` high unless a new op is accepted on the same edge. Back-to-back single-cycle ops sustain 1 op/cycle.
- `Result`/flags hold stable while `OutValid && !OutReady`.
- The unit ignores `InValid` while in MUL. Inputs are sampled only at acceptance.

## Timing
- Reset values: `OutValid`=0, `Result`=0, `Zero`=0, `Overflow`=0, `Err`=0, state=IDLE. `InReady`=1 once `Reset_n` deasserts.
- Single-cycle op accepted at edge k → `OutValid` is high from edge k.
- MUL accepted at edge k → `InReady` is low from edge k to edge k+WIDTH; `OutValid` is high from edge k+WIDTH (32 cycles at default).
- `Reset_n` asserted mid-MUL aborts the multiply immediately, returns to IDLE, and discards the partial product. No `OutValid` follows.
- When the result is pending and `OutReady`=0, `InReady`=0. There is no overwrite.

## Configuration
- `ALU_MUL_EN` defined: the MUL state and the shift-add engine are compiled in, and 1001 behaves as described above.
- `ALU_MUL_EN` undefined: 1001 is treated as reserved and completes in one cycle with `Result`=0, `Zero`=1, `Err`=1. The MUL state and datapath are not present.

## Test plan
- Reset: hold `Reset_n`=0, then release → `OutValid`=0, `Result`=0, `InReady`=1.
- ADD overflow: A=0x7FFFFFFF, B=1, code 0010 → `Result`=0x80000000, `Overflow`=1, `Zero`=0, one cycle later. SUB with A=B=5 → `Result`=0, `Zero`=1.
- Shift/compare: SLL with B=1, Shamt=31 → 0x80000000. SRL with B=0x80000000, Shamt=4 → 0x08000000. SLT with A=−1, B=1 → 1. LTZ with A=0 → 0. GEZ with A=0 → 1.
- MUL with `ALU_MUL_EN`: A=0xFFFFFFFF, B=3 → `Result`=0xFFFFFFFD, `OutValid` exactly 32 cycles after accept, `InReady`=0 throughout. Without the macro, the same stimulus gives `Result`=0, `Err`=1 after 1 cycle.
- Backpressure: hold `OutReady`=0 after an AND result → `Result` stays stable and `InReady`=0. Raise `OutReady` while presenting OR → 1 op accepted that cycle, `OutValid` stays high with the new result.
- Reset mid-MUL: assert `Reset_n` at iteration 10 → no `OutValid`, state IDLE, and the next ADD returns the correct result.
